contador_bcd: RTL and testbench

- Single-digit synchronous BCD up-counter (0..9, wraps to 0), advanced only when the clock-enable is high.
- Leaf block for timer and display chains; the terminal-count output lets several instances be cascaded into multi-digit counters.
- The optional 7-segment decode drives a display digit directly.

---
 rtl/contador_bcd_pkg.sv | 47 ++++
 rtl/contador_bcd_bcd_to_7seg.sv | 18 +
 rtl/contador_bcd.sv | 79 +++++++
 tb/tb_contador_bcd.sv | 136 +++++++++++++
 4 files changed

// File: rtl/contador_bcd_pkg.sv
// contador_bcd_pkg
//   Shared definitions for the single-digit BCD counter slice.
//   - BCD_W / BCD_MAX : digit width and last decimal value before wrap.
//   - bcd_t / seg_t   : digit and 7-segment pattern types.
//   - SEG_0..SEG_9    : active-high segment patterns, bit order {g,f,e,d,c,b,a}.
//   - SEG_BLANK       : all segments off, shown for non-decimal codes.
//   - bcd_seg()       : digit-to-pattern lookup used by the decoder.
package contador_bcd_pkg;

  localparam int BCD_W   = 4;
  localparam int BCD_MAX = 9;

  typedef logic [BCD_W-1:0] bcd_t;
  typedef logic [6:0]       seg_t;

  //                            gfedcba
  localparam seg_t SEG_0     = 7'b0111111;
  localparam seg_t SEG_1     = 7'b0000110;
  localparam seg_t SEG_2     = 7'b1011011;
  localparam seg_t SEG_3     = 7'b1001111;
  localparam seg_t SEG_4     = 7'b1100110;
  localparam seg_t SEG_5     = 7'b1101101;
  localparam seg_t SEG_6     = 7'b1111101;
  localparam seg_t SEG_7     = 7'b0000111;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1101111;
  localparam seg_t SEG_BLANK = 7'b0000000;

  // Codes 10..15 are not decimal digits; they render as a dark digit so a
  // corrupted counter is visible rather than showing a plausible number.
  function automatic seg_t bcd_seg(input bcd_t d);
    case (d)
      4'd0:    bcd_seg = SEG_0;
      4'd1:    bcd_seg = SEG_1;
      4'd2:    bcd_seg = SEG_2;
      4'd3:    bcd_seg = SEG_3;
      4'd4:    bcd_seg = SEG_4;
      4'd5:    bcd_seg = SEG_5;
      4'd6:    bcd_seg = SEG_6;
      4'd7:    bcd_seg = SEG_7;
      4'd8:    bcd_seg = SEG_8;
      4'd9:    bcd_seg = SEG_9;
      default: bcd_seg = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/contador_bcd_bcd_to_7seg.sv
// bcd_to_7seg
//   Purely combinational BCD digit to 7-segment decoder.
//   Ports:
//     bcd  in  4  digit code 0..15
//     seg  out 7  segments {g,f,e,d,c,b,a}, active-high; blank for 10..15
module bcd_to_7seg
  import contador_bcd_pkg::*;
(
  input  bcd_t bcd,
  output seg_t seg
);

  always_comb begin
    seg = SEG_BLANK;
    seg = bcd_seg(bcd);
  end

endmodule

// File: rtl/contador_bcd.sv
// contador_bcd
//   Single-digit synchronous BCD up-counter (0..MAX_COUNT, then wraps to 0),
//   advanced only on rising clk edges where clk_en is high. tc lets digits be
//   cascaded: the next digit's clk_en is this digit's tc.
//   Optional build macro: CONTADOR_BCD_SEG7_EN adds the seg output with a
//   combinational 7-segment decode of sal.
//   Parameters:
//     MAX_COUNT  last value before wrap, legal 1..15 (default 9)
//     WIDTH      counter width, must be 4
//   Ports:
//     clk     in   1  rising-edge clock
//     rst     in   1  asynchronous, active-high reset (sal -> 0 immediately)
//     clk_en  in   1  count enable
//     sal     out  4  current count, registered
//     tc      out  1  clk_en && sal == MAX_COUNT (combinational)
//     seg     out  7  {g,f,e,d,c,b,a} active-high (CONTADOR_BCD_SEG7_EN only)
module contador_bcd
  import contador_bcd_pkg::*;
#(
  parameter int MAX_COUNT = BCD_MAX,
  parameter int WIDTH     = BCD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  output logic [WIDTH-1:0] sal,
`ifdef CONTADOR_BCD_SEG7_EN
  output logic [6:0]       seg,
`endif
  output logic             tc
);

  // Configuration errors stop elaboration instead of building a bad counter.
  if (WIDTH != BCD_W) begin : g_bad_width
    $error("contador_bcd: WIDTH must be 4");
  end
  if (MAX_COUNT < 1 || MAX_COUNT > 15) begin : g_bad_max
    $error("contador_bcd: MAX_COUNT must be in 1..15");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

  // Declaration value gives a known zero at power-up even with no reset pulse.
  logic [WIDTH-1:0] cnt_q = '0;
  logic [WIDTH-1:0] cnt_d;
  logic             at_max;

  // ">=" rather than "==" folds the unreachable codes above MAX_COUNT back to
  // zero on the next enabled edge, so a corrupted value cannot persist.
  assign at_max = (cnt_q >= MAX_V);

  always_comb begin
    cnt_d = cnt_q;
    if (clk_en) cnt_d = at_max ? '0 : cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign sal = cnt_q;

  // Exact compare: an illegal code (above MAX_COUNT) wraps but is not a
  // genuine terminal count and must not ripple into the next digit.
  assign tc  = clk_en & (cnt_q == MAX_V);

`ifdef CONTADOR_BCD_SEG7_EN
  seg_t seg_w;

  bcd_to_7seg u_seg (
    .bcd (bcd_t'(cnt_q)),
    .seg (seg_w)
  );

  assign seg = seg_w;
`endif

endmodule

// File: tb/tb_contador_bcd.sv
module tb_contador_bcd;

  logic       clk;
  logic       rst;
  logic       clk_en;
  logic [3:0] sal;
  logic       tc;
`ifdef CONTADOR_BCD_SEG7_EN
  logic [6:0] seg;
  logic [6:0] seg_exp [10];
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int exp_v;

  contador_bcd dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .sal    (sal),
`ifdef CONTADOR_BCD_SEG7_EN
    .seg    (seg),
`endif
    .tc     (tc)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
`ifdef CONTADOR_BCD_SEG7_EN
    seg_exp[0] = 7'b0111111; seg_exp[1] = 7'b0000110;
    seg_exp[2] = 7'b1011011; seg_exp[3] = 7'b1001111;
    seg_exp[4] = 7'b1100110; seg_exp[5] = 7'b1101101;
    seg_exp[6] = 7'b1111101; seg_exp[7] = 7'b0000111;
    seg_exp[8] = 7'b1111111; seg_exp[9] = 7'b1101111;
`endif
    rst    = 1'b0;
    clk_en = 1'b0;

    // power-up value with no reset pulse yet
    #5;
    chk("pwrup_sal", sal, 0);

    // reset asserted between edges
    rst = 1'b1;
    #2;
    chk("rst_sal", sal, 0);
    chk("rst_tc", tc, 0);
    #4 rst = 1'b0;

    // enable low: five edges, no movement
    repeat (5) begin
      @(negedge clk);
      chk("gate_hold", sal, 0);
    end

    // enable high: 1,2,3
    clk_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("step_sal", sal, i);
      chk("step_tc", tc, 0);
    end

    // mid-count asynchronous reset, held across an enabled edge
    #3 rst = 1'b1;
    #1;
    chk("arst_now", sal, 0);
    chk("arst_tc", tc, 0);
    @(negedge clk);
    chk("arst_hold", sal, 0);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("arst_first", sal, 1);

    // continuous counting across two wraps
    exp_v = 1;
    for (int i = 0; i < 20; i++) begin
      chk("wrap_sal", sal, exp_v);
      chk("wrap_tc", tc, (exp_v == 9) ? 1 : 0);
`ifdef CONTADOR_BCD_SEG7_EN
      chk("seg_dec", seg, seg_exp[exp_v]);
`endif
      @(negedge clk);
      exp_v = (exp_v == 9) ? 0 : exp_v + 1;
    end

    // advance to 9 then drop enable: tc must follow clk_en
    repeat (8) @(negedge clk);
    chk("at9_sal", sal, 9);
    chk("at9_tc_en", tc, 1);
    clk_en = 1'b0;
    #1;
    chk("at9_tc_dis", tc, 0);
    @(negedge clk);
    chk("at9_hold", sal, 9);

    // illegal code recovers in one enabled edge without a tc pulse
    force dut.cnt_q = 4'd12;
    #1 release dut.cnt_q;
    #1;
    chk("ill_sal", sal, 12);
    clk_en = 1'b1;
    #1;
    chk("ill_tc", tc, 0);
    @(negedge clk);
    chk("ill_recover", sal, 0);

`ifdef CONTADOR_BCD_SEG7_EN
    // non-decimal codes render blank
    clk_en = 1'b0;
    for (int v = 10; v <= 15; v++) begin
      force dut.cnt_q = 4'(v);
      #1 release dut.cnt_q;
      #1;
      chk("seg_blank", seg, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
